// File: rtl/div_sched_pkg.sv
// Shared types and helpers for the shared-divider scheduler.
// Used by div_rr_arb and div_share_sched.
package div_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADB,
    S_LOADA,
    S_CHECK,
    S_SUB,
    S_DONE
  } state_t;

  // Every quotient bit is set on divide-by-zero
  localparam logic DIV0_QUOT_BIT = 1'b1;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_rr_arb.sv
// Combinational N-way round-robin pick: the first set request at or after ptr wins.
// The pointer register itself is owned by the caller.
module div_rr_arb
  import div_sched_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] id,
  output logic           valid
);

  logic [IDW-1:0] cand;

  always_comb begin
    grant = '0;
    id    = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      if (!valid) begin
        cand = IDW'((int'(ptr) + k) % N);
        if (req[cand]) begin
          valid = 1'b1;
          id    = cand;
          grant = N'(1) << cand;
        end
      end
    end
  end

endmodule

// File: rtl/div_share_sched.sv
// Schedules N requesters onto one repeated-subtraction divider datapath.
// Optional iteration watchdog enabled by defining DIVSCHED_WDOG_EN.
//
// state   | meaning
// IDLE    | waiting for a request; grant, latch operands
// LOADB   | load divisor into B, clear quotient counter
// LOADA   | load dividend into A
// CHECK   | look at lt: finish, abort on watchdog, or subtract again
// SUB     | A <= A - B, quotient counter +1
// DONE    | one-cycle ack to the granted requester
module div_share_sched
  import div_sched_pkg::*;
#(
  parameter int N          = 4,
  parameter int W          = 16,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*W-1:0]        req_dividend,
  input  logic [N*W-1:0]        req_divisor,
  output logic [N-1:0]          ack,
  output logic [W-1:0]          rsp_quot,
  output logic [W-1:0]          rsp_rem,
  output logic                  rsp_err,
  output logic [id_w(N)-1:0]    rsp_id,
  output logic                  busy,
  output logic [W-1:0]          data_out,
  output logic                  ldb,
  output logic                  lda,
  output logic                  sel,
  output logic                  ldc,
  output logic                  inc,
  input  logic                  lt,
  input  logic [W-1:0]          w,
  input  logic [W-1:0]          bout
);

  localparam int IDW = id_w(N);

  state_t         state, state_nx;
  logic [IDW-1:0] ptr, gid;
  logic [N-1:0]   gnt_oh;
  logic [W-1:0]   dvd, dvs;
  logic [W-1:0]   sel_dvd, sel_dvs;
  logic [N-1:0]   arb_oh;
  logic [IDW-1:0] arb_id;
  logic           arb_vld;
  logic           wdog_hit;

  div_rr_arb #(.N(N), .IDW(IDW)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_oh),
    .id    (arb_id),
    .valid (arb_vld)
  );

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_id == IDW'(i)) begin
        sel_dvd = req_dividend[i*W +: W];
        sel_dvs = req_divisor[i*W +: W];
      end
    end
  end

`ifdef DIVSCHED_WDOG_EN
  localparam int WCW = $clog2(WDOG_LIMIT + 1);
  logic [WCW-1:0] wcnt;

  assign wdog_hit = (wcnt == WCW'(WDOG_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (state == S_LOADA) begin
      wcnt <= '0;
    end else if (state == S_SUB) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  logic [31:0] wdog_unused;
  assign wdog_unused = 32'(WDOG_LIMIT);
  assign wdog_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gid      <= '0;
      gnt_oh   <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rsp_quot <= '0;
      rsp_rem  <= '0;
      rsp_err  <= 1'b0;
      rsp_id   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (arb_vld) begin
            gid    <= arb_id;
            gnt_oh <= arb_oh;
            dvd    <= sel_dvd;
            dvs    <= sel_dvs;
            if (sel_dvs == '0) begin
              rsp_quot <= {W{DIV0_QUOT_BIT}};
              rsp_rem  <= sel_dvd;
              rsp_err  <= 1'b1;
              rsp_id   <= arb_id;
            end
          end
        end
        S_CHECK: begin
          // Watchdog abort still reports the partial datapath state
          if (lt || wdog_hit) begin
            rsp_quot <= bout;
            rsp_rem  <= w;
            rsp_err  <= ~lt;
            rsp_id   <= gid;
          end
        end
        S_DONE: begin
          ptr <= (gid == IDW'(N - 1)) ? '0 : gid + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    ack      = '0;
    data_out = '0;
    ldb      = 1'b0;
    lda      = 1'b0;
    sel      = 1'b0;
    ldc      = 1'b0;
    inc      = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (arb_vld) state_nx = (sel_dvs == '0) ? S_DONE : S_LOADB;
      end
      S_LOADB: begin
        data_out = dvs;
        ldb      = 1'b1;
        ldc      = 1'b1;
        state_nx = S_LOADA;
      end
      S_LOADA: begin
        data_out = dvd;
        lda      = 1'b1;
        state_nx = S_CHECK;
      end
      S_CHECK: begin
        state_nx = (lt || wdog_hit) ? S_DONE : S_SUB;
      end
      S_SUB: begin
        sel      = 1'b1;
        lda      = 1'b1;
        inc      = 1'b1;
        state_nx = S_CHECK;
      end
      S_DONE: begin
        ack      = gnt_oh;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_share_sched.sv
// Bench for div_share_sched paired with a behavioural divider datapath.
// Honours DIVSCHED_WDOG_EN for the watchdog expectations.
module tb_div_share_sched;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_dividend = '0;
  logic [N*W-1:0] req_divisor = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   rsp_quot, rsp_rem, data_out, w, bout;
  logic           rsp_err, busy, ldb, lda, sel, ldc, inc, lt;
  logic [1:0]     rsp_id;

  logic [W-1:0] dp_a = '0, dp_b = '0, dp_c = '0;

  always #5 clk = ~clk;

  div_share_sched #(.N(N), .W(W), .WDOG_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dividend(req_dividend),
    .req_divisor(req_divisor), .ack(ack), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem),
    .rsp_err(rsp_err), .rsp_id(rsp_id), .busy(busy), .data_out(data_out),
    .ldb(ldb), .lda(lda), .sel(sel), .ldc(ldc), .inc(inc), .lt(lt), .w(w), .bout(bout)
  );

  // Divider datapath model
  always @(posedge clk) begin
    if (ldb) dp_b <= data_out;
    if (lda) dp_a <= sel ? dp_a - dp_b : data_out;
    if (ldc) dp_c <= '0;
    else if (inc) dp_c <= dp_c + 1'b1;
  end
  assign lt   = dp_a < dp_b;
  assign w    = dp_a;
  assign bout = dp_c;

  typedef struct {
    int           id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
  } exp_t;

  typedef struct {
    int           id;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
    int           lat;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack must match the next queued expectation
  always @(negedge clk) begin
    if (!rst && ack != '0) begin
      exp_t e;
      logic [N-1:0] oh;
      ack_count++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=%b expected none at %0t", ack, $time);
      end else begin
        e  = sbq.pop_front();
        oh = N'(1) << e.id;
        chk("ack_onehot", 32'(ack), 32'(oh));
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_quot", 32'(rsp_quot), 32'(e.q));
        chk("rsp_rem", 32'(rsp_rem), 32'(e.r));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic run_req(input int id, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ee,
                         input int elat, input bit drop_early);
    int cyc;
    bit got;
    bit strobes;
    exp_t e;
    @(negedge clk);
    req_dividend[id*W +: W] = dvd;
    req_divisor[id*W +: W]  = dvs;
    req[id] = 1'b1;
    e.id = id; e.q = eq; e.r = er; e.err = ee;
    sbq.push_back(e);
    cyc = 0; got = 1'b0; strobes = 1'b0;
    while (!got && cyc < elat + 50) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (drop_early && cyc == 1) req[id] = 1'b0;
      if (ldb || lda) strobes = 1'b1;
      if (ack[id]) got = 1'b1;
    end
    req[id] = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack expected ack[%0d] within %0d cycles", id, elat + 50);
    end else begin
      chk("latency", 32'(cyc), 32'(elat));
    end
    if (dvs == '0) chk("div0_no_strobes", 32'(strobes), 32'd0);
    repeat (2) @(negedge clk);
    chk("rsp_hold_quot", 32'(rsp_quot), 32'(eq));
    chk("rsp_hold_rem", 32'(rsp_rem), 32'(er));
  endtask

  vec_t vecs[8];

  initial begin
    int start;
    int cyc;
    exp_t e;

    vecs[0] = '{0, 16'd25,    16'd4,     16'd6,      16'd1,  1'b0, 16};
    vecs[1] = '{2, 16'd3,     16'd7,     16'd0,      16'd3,  1'b0, 4};
    vecs[2] = '{1, 16'd9,     16'd0,     16'hFFFF,   16'd9,  1'b1, 1};
    vecs[3] = '{3, 16'd0,     16'd5,     16'd0,      16'd0,  1'b0, 4};
    vecs[4] = '{1, 16'd65535, 16'd65535, 16'd1,      16'd0,  1'b0, 6};
    vecs[5] = '{2, 16'd100,   16'd7,     16'd14,     16'd2,  1'b0, 32};
    vecs[6] = '{0, 16'd1000,  16'd999,   16'd1,      16'd1,  1'b0, 6};
    vecs[7] = '{3, 16'd48,    16'd16,    16'd3,      16'd0,  1'b0, 10};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_strobes", 32'({ldb, lda, sel, ldc, inc}), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_rsp", 32'({rsp_quot, rsp_rem}), 32'd0);
    chk("rst_rsp_id_err", 32'({rsp_id, rsp_err}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_req(vecs[i].id, vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r,
              vecs[i].err, vecs[i].lat, 1'b0);

    // Request dropped right after grant still completes
    run_req(3, 16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 10, 1'b1);

    // Fairness: all four held, pointer currently at 0 after last grant to 3
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_dividend[i*W +: W] = 16'd10;
      req_divisor[i*W +: W]  = 16'd3;
    end
    foreach (vecs[i]) ;
    for (int k = 0; k < 5; k++) begin
      e.id = k % N; e.q = 16'd3; e.r = 16'd1; e.err = 1'b0;
      sbq.push_back(e);
    end
    start = ack_count;
    req = 4'b1111;
    cyc = 0;
    while (ack_count < start + 5 && cyc < 200) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      cyc++;
    end
    req = '0;
    chk("fair_ack_count", 32'(ack_count - start), 32'd5);
    chk("fair_queue_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();
    repeat (3) @(negedge clk);

    // Reset in the middle of a long division: no ack, busy drops
    req_dividend[0 +: W] = 16'd100;
    req_divisor[0 +: W]  = 16'd1;
    req[0] = 1'b1;
    cyc = 0;
    while (!inc && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("midop_reached_sub", 32'(inc), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    chk("midop_busy", 32'(busy), 32'd0);
    chk("midop_ack", 32'(ack), 32'd0);
    chk("midop_rsp_cleared", 32'({rsp_quot, rsp_err}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef DIVSCHED_WDOG_EN
    run_req(0, 16'd100, 16'd1, 16'd8, 16'd92, 1'b1, 20, 1'b0);
`else
    run_req(0, 16'd100, 16'd1, 16'd100, 16'd0, 1'b0, 204, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);
    chk("final_queue", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
